// File: rtl/pulse_player_pkg.sv
// Shared types and word-format constants for the pulse pattern player.
package pulse_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_RUN
  } state_e;

  localparam int LAST_BIT          = 31;
  localparam int LEVEL_HI          = 27;
  localparam int LEVEL_LO          = 24;
  localparam int DUR_HI            = 23;
  localparam int MIN_SEG           = 2;
  localparam int DEFAULT_MEM_DEPTH = 25000;

endpackage

// File: rtl/pulse_pattern_player_timer.sv
// Segment timer: loadable down-counter clamped to MIN_SEG cycles, flags the
// second and the final cycle of the running segment.
module pulse_segment_timer
  import pulse_player_pkg::*;
#(
  parameter int DUR_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [DUR_W-1:0] dur_i,
  output logic             last_cycle_o,
  output logic             second_cycle_o
);

  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic             first_q;
  logic             second_q;

  // cnt_q holds the number of cycles remaining after the current one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cnt_d = cnt_q;
    if (load_i) begin
      if (dur_i < DUR_W'(MIN_SEG)) cnt_d = DUR_W'(MIN_SEG - 1);
      else                         cnt_d = dur_i - DUR_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DUR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      cnt_q    <= '0;
      first_q  <= 1'b0;
      second_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      first_q  <= load_i;
      second_q <= first_q;
    end
  end

  assign last_cycle_o   = (cnt_q == '0);
  assign second_cycle_o = second_q;

endmodule

// File: rtl/pulse_pattern_player.sv
// Pulse pattern player: streams segment words from on-chip memory onto pulse_out.
// Optional feature macro: PULSE_PLAYER_LOOPCNT_EN (loop_count replaces loop_en).
module pulse_pattern_player
  import pulse_player_pkg::*;
#(
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
  parameter int ADDR_W    = 15,
  parameter int DUR_W     = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef PULSE_PLAYER_LOOPCNT_EN
  input  logic [15:0]       loop_count,
`else
  input  logic              loop_en,
`endif
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  input  logic [31:0]       mem_readdata,
  output logic [3:0]        pulse_out,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              cs_q, cs_d;
  logic [3:0]        pulse_q, pulse_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       next_word_q, next_word_d;
  logic              end_q, end_d;
`ifdef PULSE_PLAYER_LOOPCNT_EN
  logic [15:0]       pass_q, pass_d;
  logic              forever_q, forever_d;
`endif

  logic              load_seg;
  logic              timer_load;
  logic [31:0]       load_word;
  logic              cont;
  logic [ADDR_W-1:0] addr_inc;
  logic              last_cycle;
  logic              second_cycle;
  logic              unused_rsvd;

  assign unused_rsvd = ^{load_word[30:28]};

  assign addr_inc = (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

  pulse_segment_timer #(
    .DUR_W (DUR_W)
  ) u_timer (
    .clk            (clk),
    .reset          (reset),
    .load_i         (timer_load),
    .dur_i          (DUR_W'(load_word[DUR_HI:0])),
    .last_cycle_o   (last_cycle),
    .second_cycle_o (second_cycle)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    base_d      = base_q;
    cs_d        = 1'b0;
    pulse_d     = pulse_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    next_word_d = next_word_q;
    end_d       = end_q;
    load_seg    = 1'b0;
    timer_load  = 1'b0;
    load_word   = mem_readdata;
    cont        = 1'b0;
`ifdef PULSE_PLAYER_LOOPCNT_EN
    pass_d      = pass_q;
    forever_d   = forever_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_FETCH;
          addr_d  = base_addr;
          base_d  = base_addr;
          cs_d    = 1'b1;
          busy_d  = 1'b1;
`ifdef PULSE_PLAYER_LOOPCNT_EN
          pass_d    = loop_count;
          forever_d = (loop_count == 16'd0);
`endif
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        load_seg = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (second_cycle) next_word_d = mem_readdata;
        if (last_cycle) begin
          if (end_q) begin
            state_d = ST_IDLE;
            pulse_d = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // A 2-cycle segment ends on the same edge its prefetch lands.
            load_seg  = 1'b1;
            load_word = second_cycle ? mem_readdata : next_word_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_seg) begin
      pulse_d    = load_word[LEVEL_HI:LEVEL_LO];
      timer_load = 1'b1;
`ifdef PULSE_PLAYER_LOOPCNT_EN
      cont = forever_q || (pass_q != 16'd1);
      if (load_word[LAST_BIT] && !forever_q) pass_d = pass_q - 16'd1;
`else
      cont = loop_en;
`endif
      end_d = load_word[LAST_BIT] && !cont;
      if (!end_d) begin
        cs_d   = 1'b1;
        addr_d = load_word[LAST_BIT] ? base_q : addr_inc;
      end
    end

    if (stop && state_q != ST_IDLE) begin
      state_d    = ST_IDLE;
      pulse_d    = 4'd0;
      busy_d     = 1'b0;
      cs_d       = 1'b0;
      done_d     = 1'b0;
      timer_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      base_q      <= '0;
      cs_q        <= 1'b0;
      pulse_q     <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      next_word_q <= '0;
      end_q       <= 1'b0;
`ifdef PULSE_PLAYER_LOOPCNT_EN
      pass_q      <= '0;
      forever_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      cs_q        <= cs_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      next_word_q <= next_word_d;
      end_q       <= end_d;
`ifdef PULSE_PLAYER_LOOPCNT_EN
      pass_q      <= pass_d;
      forever_q   <= forever_d;
`endif
    end
  end

  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign pulse_out      = pulse_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_pulse_pattern_player.sv
// Directed bench for pulse_pattern_player with a registered-read memory model.
module tb_pulse_pattern_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [14:0] base_addr;
`ifdef PULSE_PLAYER_LOOPCNT_EN
  logic [15:0] loop_count;
`else
  logic        loop_en;
`endif
  logic [14:0] mem_address;
  logic        mem_chipselect;
  logic [31:0] mem_readdata;
  logic [3:0]  pulse_out;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:24999];

  logic [3:0]  cap_pulse [0:63];
  logic        cap_busy  [0:63];
  logic        cap_done  [0:63];
  logic        cap_cs    [0:63];
  logic [14:0] cap_addr  [0:63];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_chipselect) mem_readdata <= mem[mem_address];

  pulse_pattern_player dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .base_addr      (base_addr),
`ifdef PULSE_PLAYER_LOOPCNT_EN
    .loop_count     (loop_count),
`else
    .loop_en        (loop_en),
`endif
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_readdata   (mem_readdata),
    .pulse_out      (pulse_out),
    .busy           (busy),
    .done           (done)
  );

  task automatic set_loop(input bit l);
`ifdef PULSE_PLAYER_LOOPCNT_EN
    loop_count = l ? 16'd0 : 16'd1;
`else
    loop_en = l;
`endif
  endtask

  // Records outputs #1 after each of n edges; index 0 is edge E0 where start is sampled.
  task automatic capture(input int n, input int poke);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cap_pulse[i] = pulse_out;
      cap_busy[i]  = busy;
      cap_done[i]  = done;
      cap_cs[i]    = mem_chipselect;
      cap_addr[i]  = mem_address;
      if (i == 0 || i == poke + 1) start = 1'b0;
      if (i == poke) begin
        start     = 1'b1;
        base_addr = 15'd10;
      end
    end
  endtask

  task automatic kick(input logic [14:0] b, input int n, input int poke);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    capture(n, poke);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    total++; if (pulse_out !== 4'd0) begin bad++; $display("FAIL reset_pulse: got %0h want 0", pulse_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
    total++; if (mem_chipselect !== 1'b0) begin bad++; $display("FAIL reset_cs: got %0b want 0", mem_chipselect); end
    total++; if (mem_address !== 15'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", mem_address); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_two_word;
    logic [3:0] ep [0:10];
    ep = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 0, 0};
    set_loop(1'b0);
    kick(15'd0, 11, -1);
    for (int i = 0; i < 11; i++) begin
      total++; if (cap_pulse[i] !== ep[i]) begin bad++; $display("FAIL two_pulse[%0d]: got %0h want %0h", i, cap_pulse[i], ep[i]); end
      total++; if (cap_busy[i] !== (i < 9)) begin bad++; $display("FAIL two_busy[%0d]: got %0b want %0b", i, cap_busy[i], i < 9); end
      total++; if (cap_done[i] !== (i == 9)) begin bad++; $display("FAIL two_done[%0d]: got %0b want %0b", i, cap_done[i], i == 9); end
    end
    total++; if (cap_cs[0] !== 1'b1 || cap_addr[0] !== 15'd0) begin bad++; $display("FAIL two_fetch: got cs=%0b addr=%0d want cs=1 addr=0", cap_cs[0], cap_addr[0]); end
    total++; if (cap_cs[1] !== 1'b0) begin bad++; $display("FAIL two_cs1: got %0b want 0", cap_cs[1]); end
    total++; if (cap_cs[2] !== 1'b1 || cap_addr[2] !== 15'd1) begin bad++; $display("FAIL two_prefetch: got cs=%0b addr=%0d want cs=1 addr=1", cap_cs[2], cap_addr[2]); end
    total++; if (cap_cs[5] !== 1'b0) begin bad++; $display("FAIL two_noprefetch: got %0b want 0", cap_cs[5]); end
  endtask

  task automatic test_min_len;
    logic [3:0] ep [0:9];
    ep = '{0, 0, 3, 3, 4, 4, 5, 5, 0, 0};
    set_loop(1'b0);
    kick(15'd10, 10, -1);
    for (int i = 0; i < 10; i++) begin
      total++; if (cap_pulse[i] !== ep[i]) begin bad++; $display("FAIL min_pulse[%0d]: got %0h want %0h", i, cap_pulse[i], ep[i]); end
      total++; if (cap_done[i] !== (i == 8)) begin bad++; $display("FAIL min_done[%0d]: got %0b want %0b", i, cap_done[i], i == 8); end
    end
    total++; if (cap_cs[4] !== 1'b1 || cap_addr[4] !== 15'd12) begin bad++; $display("FAIL min_prefetch: got cs=%0b addr=%0d want cs=1 addr=12", cap_cs[4], cap_addr[4]); end
  endtask

  task automatic test_loop_stop;
    logic [3:0] exp_p;
    set_loop(1'b1);
    // A start pulse mid-run must be ignored.
    kick(15'd0, 18, 5);
    for (int i = 0; i < 18; i++) begin
      exp_p = (i < 2) ? 4'd0 : ((((i - 2) % 7) < 3) ? 4'd1 : 4'd2);
      total++; if (cap_pulse[i] !== exp_p) begin bad++; $display("FAIL loop_pulse[%0d]: got %0h want %0h", i, cap_pulse[i], exp_p); end
      total++; if (cap_busy[i] !== 1'b1) begin bad++; $display("FAIL loop_busy[%0d]: got %0b want 1", i, cap_busy[i]); end
      total++; if (cap_done[i] !== 1'b0) begin bad++; $display("FAIL loop_done[%0d]: got %0b want 0", i, cap_done[i]); end
    end
    total++; if (cap_cs[5] !== 1'b1 || cap_addr[5] !== 15'd0) begin bad++; $display("FAIL loop_restart_addr: got cs=%0b addr=%0d want cs=1 addr=0", cap_cs[5], cap_addr[5]); end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    total++; if (pulse_out !== 4'd0) begin bad++; $display("FAIL stop_pulse: got %0h want 0", pulse_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy: got %0b want 0", busy); end
    total++; if (mem_chipselect !== 1'b0) begin bad++; $display("FAIL stop_cs: got %0b want 0", mem_chipselect); end
    for (int i = 0; i < 4; i++) begin
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stop_after[%0d]: got done=%0b busy=%0b want 0 0", i, done, busy); end
      @(posedge clk); #1;
    end
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    total++; if (busy !== 1'b0 || mem_chipselect !== 1'b0) begin bad++; $display("FAIL start_stop: got busy=%0b cs=%0b want 0 0", busy, mem_chipselect); end
    set_loop(1'b0);
  endtask

  task automatic test_wrap;
    logic [3:0] ep [0:7];
    ep = '{0, 0, 6, 6, 7, 7, 0, 0};
    mem[24999] = 32'h0600_0002;
    mem[0]     = 32'h8700_0002;
    set_loop(1'b0);
    kick(15'd24999, 8, -1);
    for (int i = 0; i < 8; i++) begin
      total++; if (cap_pulse[i] !== ep[i]) begin bad++; $display("FAIL wrap_pulse[%0d]: got %0h want %0h", i, cap_pulse[i], ep[i]); end
    end
    total++; if (cap_addr[0] !== 15'd24999) begin bad++; $display("FAIL wrap_first_addr: got %0d want 24999", cap_addr[0]); end
    total++; if (cap_cs[2] !== 1'b1 || cap_addr[2] !== 15'd0) begin bad++; $display("FAIL wrap_second_addr: got cs=%0b addr=%0d want cs=1 addr=0", cap_cs[2], cap_addr[2]); end
    total++; if (cap_done[6] !== 1'b1 || cap_busy[6] !== 1'b0) begin bad++; $display("FAIL wrap_end: got done=%0b busy=%0b want 1 0", cap_done[6], cap_busy[6]); end
    mem[0] = 32'h0100_0003;
  endtask

  task automatic test_async_reset;
    set_loop(1'b0);
    kick(15'd0, 3, -1);
    total++; if (pulse_out !== 4'd1 || busy !== 1'b1 || mem_chipselect !== 1'b1) begin bad++; $display("FAIL ar_pre: got p=%0h b=%0b cs=%0b want 1 1 1", pulse_out, busy, mem_chipselect); end
    #2 reset = 1'b1;
    #1;
    total++; if (pulse_out !== 4'd0) begin bad++; $display("FAIL ar_pulse: got %0h want 0", pulse_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy: got %0b want 0", busy); end
    total++; if (mem_chipselect !== 1'b0) begin bad++; $display("FAIL ar_cs: got %0b want 0", mem_chipselect); end
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (busy !== 1'b0 || pulse_out !== 4'd0 || mem_chipselect !== 1'b0) begin bad++; $display("FAIL ar_idle[%0d]: got b=%0b p=%0h cs=%0b want 0 0 0", i, busy, pulse_out, mem_chipselect); end
    end
  endtask

`ifdef PULSE_PLAYER_LOOPCNT_EN
  task automatic test_loop_count;
    int active;
    loop_count = 16'd3;
    kick(15'd0, 26, -1);
    active = 0;
    for (int i = 0; i < 26; i++) if (cap_pulse[i] !== 4'd0) active++;
    total++; if (active != 21) begin bad++; $display("FAIL lc_active: got %0d want 21", active); end
    total++; if (cap_pulse[22] !== 4'd2 || cap_pulse[23] !== 4'd0) begin bad++; $display("FAIL lc_tail: got %0h %0h want 2 0", cap_pulse[22], cap_pulse[23]); end
    for (int i = 0; i < 26; i++) begin
      total++; if (cap_done[i] !== (i == 23)) begin bad++; $display("FAIL lc_done[%0d]: got %0b want %0b", i, cap_done[i], i == 23); end
    end
  endtask
`endif

  initial begin
    start     = 1'b0;
    stop      = 1'b0;
    base_addr = '0;
    set_loop(1'b0);
    for (int i = 0; i < 25000; i++) mem[i] = 32'h0;
    mem[0]  = 32'h0100_0003;
    mem[1]  = 32'h8200_0004;
    mem[10] = 32'h0300_0000;
    mem[11] = 32'h0400_0001;
    mem[12] = 32'h8500_0002;

    test_reset();
    test_two_word();
    test_min_len();
    test_loop_stop();
    test_wrap();
    test_async_reset();
`ifdef PULSE_PLAYER_LOOPCNT_EN
    test_loop_count();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_pattern_player.md
# pulse_pattern_player

Plays a pulse pattern stored in the system on-chip memory onto up to four output pins. It sits directly downstream of the on-chip memory and reads it through the memory's second slave port (s2) as a read-only Avalon-MM master, while the Nios side loads patterns through s1. Each 32-bit memory word is one segment: an output level held for a programmed number of clock cycles. The block prefetches one word ahead, so segments follow each other with no gap.

## Interface
Parameters:
- MEM_DEPTH, 25000: words in the memory; valid addresses are 0..MEM_DEPTH-1.
- ADDR_W, 15: memory address width.
- DUR_W, 24: width of the duration field.

Ports:
- clk  in  1  system clock; the block has one clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins playback at base_addr. Ignored while busy.
- stop  in  1  synchronous abort. Has priority over start.
- base_addr  in  ADDR_W  address of the first word; sampled when start is accepted.
- loop_en  in  1  at a last word: 1 = restart at base_addr, 0 = finish. Absent when PULSE_PLAYER_LOOPCNT_EN is defined.
- mem_address  out  ADDR_W  read address; registered.
- mem_chipselect  out  1  read strobe; registered.
- mem_readdata  in  32  read data; valid in the cycle after a strobe is registered by the memory.
- pulse_out  out  4  current segment level; registered.
- busy  out  1  high from start acceptance until the last segment ends.
- done  out  1  one-cycle pulse when playback finishes normally.

## Operation
- Word format:
  - bit 31 LAST marks the final word of the pattern.
  - bits 30:28 are reserved; they are ignored.
  - bits 27:24 LEVEL is the value driven on pulse_out.
  - bits 23:0 DUR is the segment length.
- Segment length is max(DUR, 2) cycles. The 2-cycle minimum is what makes seamless prefetch possible.
- States: IDLE, FETCH, WAIT, RUN.
- IDLE:
  - pulse_out=0, busy=0, mem_chipselect=0.
  - start moves the block to FETCH with mem_address=base_addr.
- FETCH: mem_chipselect=1 for exactly one cycle, then WAIT.
- WAIT:
  - mem_readdata is captured as the current word.
  - pulse_out is updated to LEVEL on the edge that leaves WAIT.
  - The segment counter is loaded and the state becomes RUN.
- RUN:
  - In the first cycle of each segment, one prefetch read is issued for the next address. It is not issued after a LAST word when looping is off.
  - The prefetched word is captured in the segment's second cycle.
  - On the final edge of a segment, the prefetched word becomes current. pulse_out changes on that same edge.
- Next address:
  - After a LAST word with looping: base_addr.
  - Otherwise addr+1. MEM_DEPTH-1 wraps to 0.
- Finish: after a LAST segment with looping off, at the final edge:
  - pulse_out=0, busy=0, state IDLE.
  - done=1 for that one cycle.
- stop in any non-IDLE state: on the next edge the block goes to IDLE with pulse_out=0. done is not asserted and any outstanding prefetch is discarded.
- start together with stop: stop wins and start is dropped.
- mem_write does not exist; the block never writes the memory.

## Timing
- Reset values:
  - pulse_out=0, busy=0, done=0.
  - mem_chipselect=0, mem_address=0.
  - State IDLE.
- Reset clears all state asynchronously, including in mid-segment.
- Start latency: start is sampled at edge E0.
  - busy=1 and mem_chipselect=1 from E0.
  - Data arrives in the cycle after E1.
  - pulse_out shows the first LEVEL from E2.
- Segment boundaries are back-to-back with zero dead cycles, including across a loop restart.
- done rises on the same edge that pulse_out returns to 0.

## Configuration
- PULSE_PLAYER_LOOPCNT_EN defined:
  - loop_en is removed; input loop_count[15:0] is added.
  - loop_count is sampled at start.
  - 0 = repeat forever; N = play the pattern N times, then finish with done.
  - An internal 16-bit pass counter decrements at each LAST word.
- Undefined: loop_en behaves as described in Operation, and there is no pass counter.

## Structure
- Shared package pulse_player_pkg holds:
  - the state enum;
  - field constants LAST_BIT=31, LEVEL_HI=27, LEVEL_LO=24, DUR_HI=23;
  - MIN_SEG=2;
  - the default MEM_DEPTH=25000.
- One sub-module, pulse_segment_timer: a loadable down-counter with clamp-to-MIN_SEG that outputs a last_cycle flag and a second_cycle flag.

## Test plan
- Two-word pattern, looping off:
  - Stimulus: mem[0]={0,L=1,D=3}, mem[1]={LAST,L=2,D=4}; start with base_addr=0, loop_en=0.
  - Response: pulse_out 0x1 for 3 cycles then 0x2 for 4 cycles, starting at E2. Then 0, with done for 1 cycle and busy falling on the same edge.
- Minimum length:
  - Stimulus: words with D=0, D=1, D=2.
  - Response: each segment lasts exactly 2 cycles with no gaps.
- Loop and stop:
  - Stimulus: the two-word pattern with loop_en=1; stop during the third pass.
  - Response: seamless 1,1,1,2,2,2,2 repetition; on stop, pulse_out=0 and busy=0 on the next edge, and done stays 0.
- Address wrap:
  - Stimulus: base_addr=24999 with a non-LAST word there and mem[0] marked LAST.
  - Response: the second fetch uses mem_address=0 and playback ends after 2 segments.
- Asynchronous reset:
  - Stimulus: reset asserted mid-segment, between clock edges.
  - Response: pulse_out, busy and mem_chipselect go to 0 immediately; after release the block is IDLE.
- With PULSE_PLAYER_LOOPCNT_EN defined:
  - Stimulus: loop_count=3.
  - Response: exactly 3 passes (21 cycles for the two-word pattern), then done.
